// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states and datapath select codes.
// S_JAL_WB is only reachable when MIPS_CTRL_JAL_EN is defined.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL_WB   = 4'd12,
    S_HALT     = 4'd13
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILLEGAL, CLS_LW, CLS_SW, CLS_RTYPE, CLS_JR,
    CLS_IALU, CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL
  } instr_class_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_SLT   = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_RS = 2'b11} pc_src_e;
  typedef enum logic [1:0] {SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} alu_src_b_e;
  typedef enum logic [1:0] {RDST_RT = 2'b00, RDST_RD = 2'b01, RDST_RA = 2'b10} reg_dst_e;
  typedef enum logic [1:0] {M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10} mem_to_reg_e;

  // ALU operation for the immediate-ALU group; unsigned variants share the signed code.
  function automatic alu_op_e ialu_op(input logic [5:0] opcode);
    case (opcode)
      OP_ANDI:          return ALU_AND;
      OP_ORI:           return ALU_OR;
      OP_SLTI, OP_SLTIU: return ALU_SLT;
      default:          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bus between the multi-cycle controller (master) and the datapath (slave).
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       ext_type;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic [1:0] fault;
  logic [3:0] state;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, ext_type, reg_dst, mem_to_reg, reg_write, fault, state
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, ext_type, reg_dst, mem_to_reg, reg_write, fault, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl_decode.sv
// Opcode/funct classifier for the multi-cycle controller, plus immediate extension type.
// Without MIPS_CTRL_JAL_EN, jal and jr classify as illegal.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e instr_class,
  output logic         ext_type
);

  always_comb begin
    instr_class = CLS_ILLEGAL;
    ext_type    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
`ifdef MIPS_CTRL_JAL_EN
          instr_class = CLS_JR;
`else
          instr_class = CLS_ILLEGAL;
`endif
        end else begin
          instr_class = CLS_RTYPE;
        end
      end
      OP_LW:  instr_class = CLS_LW;
      OP_SW:  instr_class = CLS_SW;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: instr_class = CLS_IALU;
      // Logical immediates are zero-extended; everything else sign-extends.
      OP_ANDI, OP_ORI: begin
        instr_class = CLS_IALU;
        ext_type    = 1'b0;
      end
      OP_BEQ: instr_class = CLS_BEQ;
      OP_BNE: instr_class = CLS_BNE;
      OP_J:   instr_class = CLS_J;
      OP_JAL: begin
`ifdef MIPS_CTRL_JAL_EN
        instr_class = CLS_JAL;
`else
        instr_class = CLS_ILLEGAL;
`endif
      end
      default: instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over one memory
// port and flags illegal opcodes and memory timeouts. jal/jr support is enabled by MIPS_CTRL_JAL_EN.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input logic clk,
  input logic rst_n,
  mips_multicycle_ctrl_if.master bus
);

  localparam logic [8:0] WAIT_LIMIT = 9'(MAX_WAIT);

  state_e       state_reg, state_next;
  logic [7:0]   wait_cnt_reg, wait_cnt_next;
  logic [1:0]   fault_reg, fault_next;
  logic [8:0]   wait_inc;
  instr_class_e instr_class;
  logic         ext_type_dec;

  logic        mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, ext_type, reg_write;
  pc_src_e     pc_src;
  alu_src_b_e  alu_src_b;
  alu_op_e     alu_op;
  reg_dst_e    reg_dst;
  mem_to_reg_e mem_to_reg;

  mips_ctrl_decode u_decode (
    .opcode      (bus.opcode),
    .funct       (bus.funct),
    .instr_class (instr_class),
    .ext_type    (ext_type_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
      fault_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      fault_reg    <= fault_next;
    end
  end

  assign wait_inc = {1'b0, wait_cnt_reg} + 9'd1;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    fault_next    = fault_reg;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PCS_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    ext_type      = 1'b0;
    reg_dst       = RDST_RT;
    mem_to_reg    = M2R_ALUOUT;
    reg_write     = 1'b0;

    // Outputs stay at their zero defaults while reset is asserted.
    if (rst_n) begin
      ext_type = ext_type_dec;
      case (state_reg)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (bus.mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          case (instr_class)
            CLS_LW, CLS_SW:   state_next = S_MEM_ADDR;
            CLS_RTYPE:        state_next = S_R_EXEC;
            CLS_IALU:         state_next = S_I_EXEC;
            CLS_BEQ, CLS_BNE: state_next = S_BRANCH;
            CLS_J, CLS_JAL, CLS_JR: state_next = S_JUMP;
            default: begin
              state_next    = S_HALT;
              fault_next[0] = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          state_next = (instr_class == CLS_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (bus.mem_ready) state_next = S_MEM_WB;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (bus.mem_ready) state_next = S_FETCH;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
          state_next = S_FETCH;
        end
        S_R_EXEC: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_FUNCT;
          state_next = S_R_WB;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = RDST_RD;
          state_next = S_FETCH;
        end
        S_I_EXEC: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          alu_op     = ialu_op(bus.opcode);
          state_next = S_I_WB;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = PCS_ALUOUT;
          pc_write   = (instr_class == CLS_BNE) ? !bus.alu_zero : bus.alu_zero;
          state_next = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = (instr_class == CLS_JR) ? PCS_RS : PCS_JUMP;
`ifdef MIPS_CTRL_JAL_EN
          state_next = (instr_class == CLS_JAL) ? S_JAL_WB : S_FETCH;
`else
          state_next = S_FETCH;
`endif
        end
`ifdef MIPS_CTRL_JAL_EN
        S_JAL_WB: begin
          reg_write  = 1'b1;
          reg_dst    = RDST_RA;
          mem_to_reg = M2R_PC;
          state_next = S_FETCH;
        end
`endif
        S_HALT:  state_next = S_HALT;
        default: state_next = S_HALT;
      endcase
    end

    // A stalled request counts toward the timeout; completion clears the count.
    if (mem_req && !bus.mem_ready) begin
      wait_cnt_next = wait_inc[7:0];
      if (wait_inc >= WAIT_LIMIT) begin
        state_next    = S_HALT;
        fault_next[1] = 1'b1;
      end
    end else if (mem_req) begin
      wait_cnt_next = '0;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.iord       = iord;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.ext_type   = ext_type;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.fault      = fault_reg;
  assign bus.state      = state_reg;

endmodule
